// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment constants and hex-to-segment table
//
// Purpose: constants shared by the 7-segment scan controller and its decoder.
//   SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit seg bus
//   SEG_OFF              : all segments dark
//   HEX7_TABLE           : nibble 0..F -> {g,f,e,d,c,b,a}, active-high
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7_decode.sv
// rtl/hex7_decode.sv - combinational hex nibble to 7-segment decoder
//
// Purpose: maps one hex nibble onto the active-high a..g segment pattern.
// Ports:
//   nibble  in   4  hex value 0..F
//   segs    out  7  {g,f,e,d,c,b,a}
module hex7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);
  import seg_pkg::*;

  assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment scan controller
//
// Purpose: latches display content into a shadow bank on load, promotes it to
// the active bank only on frame boundaries, and scans DIGITS common-cathode
// digits with a per-slot blanking window and a frame-counted blink phase.
// Ports:
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   data         in   4*DIGITS  hex nibbles, digit 0 in the top nibble
//   dp           in   DIGITS    decimal-point mask, bit DIGITS-1 = digit 0
//   enable       in   DIGITS    digit enable mask, same order as dp
//   blink        in   DIGITS    blink mask, same order as dp
//   load         in   1         capture data/dp/enable/blink into shadow bank
//   frame_start  out  1         one-cycle pulse as digit 0's slot begins
//   cat          out  DIGITS    cathodes, active-low, bit DIGITS-1 = digit 0
//   seg          out  8         segments, active-high, seg[7] = dp
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     enable,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  load,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     cat,
  output logic [7:0]            seg
);
  import seg_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic [FRM_W-1:0]    frm_cnt;
  logic                blink_phase;

  logic [4*DIGITS-1:0] sh_data,  act_data;
  logic [DIGITS-1:0]   sh_dp,    act_dp;
  logic [DIGITS-1:0]   sh_en,    act_en;
  logic [DIGITS-1:0]   sh_blink, act_blink;

  logic                div_wrap;
  logic                boundary;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_blink;
  logic [DIGITS-1:0]   sel_mask;
  logic                lit;
  logic [6:0]          dec_segs;
  logic [7:0]          seg_lit;

  assign div_wrap = (div == DIV_LAST);
  assign boundary = div_wrap && (idx == IDX_LAST);

  // Pick the active-bank fields of the digit currently being scanned.
  // Digit i lives at bit DIGITS-1-i of the masks and nibble DIGITS-1-i of data.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    sel_mask  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib                = act_data[4*(DIGITS-1-i) +: 4];
        cur_dp                 = act_dp[DIGITS-1-i];
        cur_en                 = act_en[DIGITS-1-i];
        cur_blink              = act_blink[DIGITS-1-i];
        sel_mask[DIGITS-1-i]   = 1'b1;
      end
    end
  end

  hex7_decode u_hex7_decode (
    .nibble (cur_nib),
    .segs   (dec_segs)
  );

  always_comb begin
    seg_lit                = SEG_OFF;
    seg_lit[SEG_G:SEG_A]   = dec_segs;
    seg_lit[SEG_DP]        = cur_dp;
  end

  assign lit = (div >= BLANK_END) && cur_en && !(cur_blink && blink_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      idx         <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      act_blink   <= '0;
      frame_start <= 1'b0;
      cat         <= '1;
      seg         <= SEG_OFF;
    end else begin
      // Outputs use the pre-update counters and active bank, so they trail
      // the scan state by exactly one cycle.
      frame_start <= boundary;
      cat         <= lit ? ~sel_mask : '1;
      seg         <= lit ? seg_lit : SEG_OFF;

      div <= div_wrap ? '0 : div + 1'b1;
      if (div_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (load) begin
        sh_data  <= data;
        sh_dp    <= dp;
        sh_en    <= enable;
        sh_blink <= blink;
      end

      if (boundary) begin
        // A load landing on the boundary itself bypasses the shadow bank so
        // it is not delayed by a whole frame.
        act_data  <= load ? data   : sh_data;
        act_dp    <= load ? dp     : sh_dp;
        act_en    <= load ? enable : sh_en;
        act_blink <= load ? blink  : sh_blink;

        if (frm_cnt == FRM_LAST) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SDIV   = 4;
  localparam int BLANK  = 1;
  localparam int BF     = 2;
  localparam int FRAME  = DIGITS * SDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  enable = '0;
  logic [3:0]  blink = '0;
  logic        load = 1'b0;
  logic        frame_start;
  logic [3:0]  cat;
  logic [7:0]  seg;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SDIV),
    .BLANK_CYCLES (BLANK),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .dp          (dp),
    .enable      (enable),
    .blink       (blink),
    .load        (load),
    .frame_start (frame_start),
    .cat         (cat),
    .seg         (seg)
  );

  typedef struct packed {
    logic [3:0] cat;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: cycle count since reset plus per-digit banks.
  int         c;
  logic [3:0] sh_nib[4], act_nib[4];
  bit         sh_dp[4], act_dpm[4], sh_en[4], act_en[4], sh_bl[4], act_bl[4];

  function automatic logic [6:0] hex_pat(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic void model_reset();
    c = 0;
    for (int k = 0; k < 4; k++) begin
      sh_nib[k] = '0; act_nib[k] = '0;
      sh_dp[k] = 0; act_dpm[k] = 0; sh_en[k] = 0; act_en[k] = 0; sh_bl[k] = 0; act_bl[k] = 0;
    end
  endfunction

  // Called right after each rising edge with the inputs that edge sampled.
  function automatic void model_edge();
    int p, d, s, frame, phase;
    bit lit;
    logic [3:0] m;
    exp_t e;
    p     = c % FRAME;
    d     = p / SDIV;
    s     = p % SDIV;
    frame = c / FRAME;
    phase = (frame / BF) % 2;
    lit   = (s >= BLANK) && act_en[d] && !(act_bl[d] && phase == 1);
    m     = 4'b1000;
    m     = m >> d;
    e.cat = lit ? ~m : 4'hF;
    e.seg = lit ? {act_dpm[d], hex_pat(act_nib[d])} : 8'h00;
    e.fs  = (p == FRAME - 1);
    exp_q.push_back(e);
    if (load) begin
      for (int k = 0; k < 4; k++) begin
        sh_nib[k] = data[4*(3-k) +: 4];
        sh_dp[k]  = dp[3-k];
        sh_en[k]  = enable[3-k];
        sh_bl[k]  = blink[3-k];
      end
    end
    if (p == FRAME - 1) begin
      for (int k = 0; k < 4; k++) begin
        act_nib[k] = sh_nib[k]; act_dpm[k] = sh_dp[k]; act_en[k] = sh_en[k]; act_bl[k] = sh_bl[k];
      end
    end
    c++;
  endfunction

  // Monitor: one registered output set per cycle, compared away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (cat !== e.cat || seg !== e.seg || frame_start !== e.fs) begin
        n_err++;
        $display("FAIL scan t=%0t got cat=%b seg=%h fs=%b expected cat=%b seg=%h fs=%b",
                 $time, cat, seg, frame_start, e.cat, e.seg, e.fs);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] ce, input logic [7:0] se, input logic fe);
    n_vec++;
    if (cat !== ce || seg !== se || frame_start !== fe) begin
      n_err++;
      $display("FAIL %s got cat=%b seg=%h fs=%b expected cat=%b seg=%h fs=%b",
               name, cat, seg, frame_start, ce, se, fe);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data   = 16'($urandom);
      dp     = 4'($urandom);
      enable = 4'($urandom);
      blink  = 4'($urandom);
      load   = 1'b0;
      step();
    end
  endtask

  task automatic load_cycle(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p, input logic [3:0] b);
    data = d; enable = e; dp = p; blink = b; load = 1'b1;
    step();
  endtask

  task automatic run_to(input int pos);
    while ((c % FRAME) != pos) idle(1);
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'hF, 8'h00, 1'b0);
    release_reset();

    idle(2 * FRAME + 3);

    run_to(5);
    load_cycle(16'h12A8, 4'hF, 4'b0001, 4'h0);
    idle(2 * FRAME);

    load_cycle(16'h12A8, 4'b1010, 4'b0001, 4'h0);
    idle(2 * FRAME);

    load_cycle(16'h3C5E, 4'hF, 4'b0110, 4'b1000);
    idle(7 * FRAME);

    run_to(3);
    load_cycle(16'h1111, 4'hF, 4'h0, 4'h0);
    idle(2);
    load_cycle(16'h2222, 4'hF, 4'h0, 4'h0);
    idle(2 * FRAME);

    run_to(FRAME - 1);
    load_cycle(16'h9F07, 4'hF, 4'b1001, 4'h0);
    idle(FRAME + 4);

    load_cycle(16'h12A8, 4'hF, 4'h0, 4'h0);
    idle(FRAME + 2);
    run_to(9);
    idle(1);
    exp_q.delete();
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_slot", 4'hF, 8'h00, 1'b0);
    release_reset();
    idle(2 * FRAME);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        load_cycle(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
